// File: rtl/ssk_pkg.sv
// Shared configuration for the session-key bank: geometry, derived widths and FSM states.
package ssk_pkg;

    localparam int NSLOT  = 8;
    localparam int NWORD  = 12;
    localparam int DW     = 32;
    localparam int LDW    = 384;
    localparam int LIFE_W = 32;

    localparam int MAXLD   = LDW / DW;
    localparam int SLOT_AW = $clog2(NSLOT);
    localparam int WORD_AW = $clog2(NWORD);
    localparam int LD_NW   = $clog2(MAXLD) + 1;
    // A bulk load may not run past either the slot or the load bus.
    localparam int LD_MAX  = (NWORD < MAXLD) ? NWORD : MAXLD;

    typedef enum logic {
        IDLE = 1'b0,
        ZERO = 1'b1
    } state_e;

endpackage

// File: rtl/ssk_life_timer.sv
// Session lifetime counter: loads a tick budget and pulses expired_o when it runs out.
module ssk_life_timer
    import ssk_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [LIFE_W-1:0] val_i,
    input  logic              tick_i,
    output logic              expired_o
);

    logic [LIFE_W-1:0] count_q;
    logic              running_q;
    logic              expired_q;

    // A load always beats a coincident tick; a zero load simply parks the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (load_i) begin
                count_q   <= val_i;
                running_q <= (val_i != '0);
            end else if (tick_i && running_q) begin
                count_q <= count_q - LIFE_W'(1);
                if (count_q == LIFE_W'(1)) begin
                    running_q <= 1'b0;
                    expired_q <= 1'b1;
                end
            end
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/ssk_bank.sv
// Session-key bank: CPU word writes, bulk loads from the KDF, registered key/word reads,
// per-slot valid flags and a slot-per-cycle zeroize sweep triggered by request or expiry.
module ssk_bank
    import ssk_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    input  logic                life_load,
    input  logic [LIFE_W-1:0]   life_val,
    input  logic                life_tick,
    output logic                expired,
    output logic                busy,
    input  logic                wr_en,
    input  logic [SLOT_AW-1:0]  wr_slot,
    input  logic [WORD_AW-1:0]  wr_word,
    input  logic [DW-1:0]       wr_d,
    input  logic [SLOT_AW-1:0]  rd_slot,
    input  logic [WORD_AW-1:0]  rd_word,
    output logic [DW-1:0]       rd_d,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [SLOT_AW-1:0]  ld_slot,
    input  logic [LD_NW-1:0]    ld_nword,
    input  logic [LDW-1:0]      ld_data,
    output logic                ld_err,
    input  logic [SLOT_AW-1:0]  key_slot,
    output logic [NWORD*DW-1:0] key_data,
    output logic [NSLOT-1:0]    slot_valid
);

    state_e              state_q;
    logic [SLOT_AW-1:0]  sweepIdx_q;
    logic [DW-1:0]       mem_q [NSLOT][NWORD];
    logic [NSLOT-1:0]    valid_q;
    logic [DW-1:0]       rdData_q;
    logic [NWORD*DW-1:0] keyData_q;
    logic                ldErr_q;

    logic                lifeExpired;
    logic                zeroStart;
    logic                wrOk;
    logic                ldAccept;
    logic                ldBad;
    logic [DW-1:0]       rdData_d;
    logic [NWORD*DW-1:0] keyData_d;

    ssk_life_timer uLifeTimer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (life_load),
        .val_i     (life_val),
        .tick_i    (life_tick),
        .expired_o (lifeExpired)
    );

    assign zeroStart = (state_q == IDLE) && (clr_req || lifeExpired);
    assign wrOk      = (state_q == IDLE) && !zeroStart && wr_en &&
                       (int'(wr_slot) < NSLOT) && (int'(wr_word) < NWORD);
    assign ld_ready  = !rst && (state_q == IDLE) && !wr_en && !clr_req && !lifeExpired;
    assign ldAccept  = ld_valid && ld_ready;
    assign ldBad     = (ld_nword == '0) || (int'(ld_nword) > LD_MAX) ||
                       (int'(ld_slot) >= NSLOT);

    // Read paths go dark for the whole sweep so no half-cleared key can leak out.
    always_comb begin
        rdData_d  = '0;
        keyData_d = '0;
        if (state_q == IDLE) begin
            if ((int'(rd_slot) < NSLOT) && (int'(rd_word) < NWORD))
                rdData_d = mem_q[rd_slot][rd_word];
            if ((int'(key_slot) < NSLOT) && valid_q[key_slot])
                for (int w = 0; w < NWORD; w++)
                    keyData_d[(NWORD-1-w)*DW +: DW] = mem_q[key_slot][w];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sweepIdx_q <= '0;
            valid_q    <= '0;
            rdData_q   <= '0;
            keyData_q  <= '0;
            ldErr_q    <= 1'b0;
            for (int s = 0; s < NSLOT; s++)
                for (int w = 0; w < NWORD; w++)
                    mem_q[s][w] <= '0;
        end else begin
            rdData_q  <= rdData_d;
            keyData_q <= keyData_d;
            ldErr_q   <= ldAccept && ldBad;
            case (state_q)
                IDLE: begin
                    if (zeroStart) begin
                        state_q    <= ZERO;
                        sweepIdx_q <= '0;
                    end else if (wrOk) begin
                        // Writing word 0 starts a fresh key, so stale tail words are dropped.
                        if (wr_word == '0) begin
                            for (int w = 0; w < NWORD; w++)
                                mem_q[wr_slot][w] <= (w == 0) ? wr_d : '0;
                            valid_q[wr_slot] <= 1'b1;
                        end else begin
                            mem_q[wr_slot][wr_word] <= wr_d;
                        end
                    end else if (ldAccept && !ldBad) begin
                        for (int w = 0; w < NWORD; w++)
                            mem_q[ld_slot][w] <= (w < int'(ld_nword)) ?
                                                 ld_data[LDW-1-(w % MAXLD)*DW -: DW] : '0;
                        valid_q[ld_slot] <= 1'b1;
                    end
                end
                ZERO: begin
                    for (int w = 0; w < NWORD; w++)
                        mem_q[sweepIdx_q][w] <= '0;
                    valid_q[sweepIdx_q] <= 1'b0;
                    if (clr_req)
                        sweepIdx_q <= '0;
                    else if (sweepIdx_q == SLOT_AW'(NSLOT-1))
                        state_q <= IDLE;
                    else
                        sweepIdx_q <= sweepIdx_q + SLOT_AW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign expired    = lifeExpired;
    assign busy       = (state_q == ZERO);
    assign rd_d       = rdData_q;
    assign key_data   = keyData_q;
    assign ld_err     = ldErr_q;
    assign slot_valid = valid_q;

endmodule

// File: tb/tb_ssk_bank.sv
// Self-checking bench for ssk_bank: directed scenarios plus randomized traffic scored
// against a slot/word array model with a plain tick-budget lifetime.
module tb_ssk_bank;

    logic         clk, rst;
    logic         clrReq, lifeLoad, lifeTick;
    logic [31:0]  lifeVal;
    logic         expired, busy;
    logic         wrEn;
    logic [2:0]   wrSlot, rdSlot, ldSlot, keySlot;
    logic [3:0]   wrWord, rdWord;
    logic [31:0]  wrD, rdD;
    logic         ldValid, ldReady, ldErr;
    logic [4:0]   ldNword;
    logic [383:0] ldData, keyData;
    logic [7:0]   slotValid;

    int checks = 0;
    int failures = 0;

    logic [31:0]  mMem [8][12];
    logic [7:0]   mValid;
    bit           mZeroing;
    int           mSweepPos;
    longint       mLife;
    bit           mExpired, mLdErr;
    logic [31:0]  mRd;
    logic [383:0] mKey;

    ssk_bank dut (
        .clk(clk), .rst(rst), .clr_req(clrReq), .life_load(lifeLoad), .life_val(lifeVal),
        .life_tick(lifeTick), .expired(expired), .busy(busy), .wr_en(wrEn), .wr_slot(wrSlot),
        .wr_word(wrWord), .wr_d(wrD), .rd_slot(rdSlot), .rd_word(rdWord), .rd_d(rdD),
        .ld_valid(ldValid), .ld_ready(ldReady), .ld_slot(ldSlot), .ld_nword(ldNword),
        .ld_data(ldData), .ld_err(ldErr), .key_slot(keySlot), .key_data(keyData),
        .slot_valid(slotValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [383:0] obs, input logic [383:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clearInputs();
        clrReq = 0; lifeLoad = 0; lifeTick = 0; lifeVal = 0;
        wrEn = 0; wrSlot = 0; wrWord = 0; wrD = 0;
        rdSlot = 0; rdWord = 0; keySlot = 0;
        ldValid = 0; ldSlot = 0; ldNword = 0; ldData = '0;
    endtask

    task automatic resetModel();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 12; w++)
                mMem[s][w] = 32'h0;
        mValid = 8'h0; mZeroing = 0; mSweepPos = 0;
        mLife = 0; mExpired = 0; mLdErr = 0; mRd = 32'h0; mKey = '0;
    endtask

    // One clock of the reference: reads see pre-edge contents, then state advances.
    task automatic modelStep();
        bit expNow, readyNow, badLoad;
        int nw;
        expNow   = mExpired;
        readyNow = !mZeroing && !wrEn && !clrReq && !expNow;
        mRd = 32'h0;
        mKey = '0;
        if (!mZeroing) begin
            if (rdWord < 12) mRd = mMem[rdSlot][rdWord];
            if (mValid[keySlot])
                for (int i = 0; i < 12; i++) mKey[383-32*i -: 32] = mMem[keySlot][i];
        end
        nw = int'(ldNword);
        badLoad = (nw == 0) || (nw > 12);
        mLdErr = ldValid && readyNow && badLoad;
        if (mZeroing) begin
            for (int i = 0; i < 12; i++) mMem[mSweepPos][i] = 32'h0;
            mValid[mSweepPos] = 1'b0;
            if (clrReq) mSweepPos = 0;
            else begin
                mSweepPos++;
                if (mSweepPos == 8) mZeroing = 0;
            end
        end else if (clrReq || expNow) begin
            mZeroing = 1; mSweepPos = 0;
        end else if (wrEn) begin
            if (wrWord == 0) begin
                for (int i = 0; i < 12; i++) mMem[wrSlot][i] = 32'h0;
                mMem[wrSlot][0] = wrD;
                mValid[wrSlot] = 1'b1;
            end else if (wrWord < 12) begin
                mMem[wrSlot][wrWord] = wrD;
            end
        end else if (ldValid && readyNow && !badLoad) begin
            for (int i = 0; i < 12; i++) mMem[ldSlot][i] = (i < nw) ? ldData[383-32*i -: 32] : 32'h0;
            mValid[ldSlot] = 1'b1;
        end
        mExpired = 0;
        if (lifeLoad) mLife = lifeVal;
        else if (lifeTick && mLife > 0) begin
            mLife--;
            if (mLife == 0) mExpired = 1;
        end
    endtask

    // Called at a negedge with inputs set; checks ld_ready, clocks once, checks outputs.
    task automatic applyStimulus();
        #1;
        checkOutput("ld_ready", ldReady, !mZeroing && !wrEn && !clrReq && !mExpired);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("rd_d", rdD, mRd);
        checkOutput("key_data", keyData, mKey);
        checkOutput("slot_valid", slotValid, mValid);
        checkOutput("busy", busy, mZeroing);
        checkOutput("expired", expired, mExpired);
        checkOutput("ld_err", ldErr, mLdErr);
        @(negedge clk);
    endtask

    task automatic fillAllSlots();
        clearInputs();
        for (int s = 0; s < 8; s++) begin
            wrEn = 1; wrSlot = 3'(s); wrWord = 0; wrD = 32'h100 + s;
            applyStimulus();
        end
        clearInputs();
    endtask

    logic [383:0] expKey;
    logic [7:0]   expValid;

    initial begin
        clearInputs();
        resetModel();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_rd_d", rdD, 32'h0);
        checkOutput("reset_key", keyData, '0);
        checkOutput("reset_valid", slotValid, 8'h0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ld_ready", ldReady, 1'b0);
        @(negedge clk);
        rst = 0;

        wrEn = 1; wrSlot = 2; wrWord = 0; wrD = 32'hA5A5A5A5;
        applyStimulus();
        wrWord = 5; wrD = 32'h12345678;
        applyStimulus();
        clearInputs();
        rdSlot = 2; rdWord = 5; keySlot = 2;
        applyStimulus();
        checkOutput("tp1_valid", slotValid, 8'h04);
        checkOutput("tp1_rd", rdD, 32'h12345678);
        checkOutput("tp1_key", keyData, {32'hA5A5A5A5, 128'h0, 32'h12345678, 192'h0});

        ldValid = 1; ldSlot = 1; ldNword = 8;
        ldData = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, {4{32'hFFFFFFFF}}};
        applyStimulus();
        ldValid = 0; keySlot = 1;
        applyStimulus();
        expKey = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 128'h0};
        checkOutput("tp2_key", keyData, expKey);
        checkOutput("tp2_valid", slotValid, 8'h06);
        ldValid = 1; ldNword = 0; ldData = {12{32'hCAFEF00D}};
        applyStimulus();
        checkOutput("tp2_err", ldErr, 1'b1);
        ldValid = 0;
        applyStimulus();
        checkOutput("tp2_unchanged", keyData, expKey);

        clearInputs();
        wrEn = 1; wrSlot = 3; wrWord = 0; wrD = 32'hDEADBEEF;
        ldValid = 1; ldSlot = 4; ldNword = 2; ldData = {32'h11111111, 32'h22222222, 320'h0};
        #1;
        checkOutput("tp3_ready_low", ldReady, 1'b0);
        applyStimulus();
        wrEn = 0;
        applyStimulus();
        ldValid = 0; keySlot = 4; rdSlot = 3; rdWord = 0;
        applyStimulus();
        checkOutput("tp3_load", keyData, {32'h11111111, 32'h22222222, 320'h0});
        checkOutput("tp3_write", rdD, 32'hDEADBEEF);
        checkOutput("tp3_valid", slotValid, 8'h1E);

        fillAllSlots();
        clrReq = 1;
        applyStimulus();
        checkOutput("tp4_busy0", busy, 1'b1);
        checkOutput("tp4_valid0", slotValid, 8'hFF);
        clrReq = 0;
        for (int k = 1; k <= 8; k++) begin
            wrEn = 1; wrSlot = 3'(k); wrWord = 0; wrD = $urandom();
            ldValid = 1; ldSlot = 3'(k); ldNword = 3;
            applyStimulus();
            expValid = 8'hFF;
            expValid = expValid << k;
            checkOutput("tp4_sweep_valid", slotValid, expValid);
            checkOutput("tp4_sweep_busy", busy, k < 8);
        end
        clearInputs();
        for (int s = 0; s < 8; s++) begin
            rdSlot = 3'(s); rdWord = 4'(s);
            applyStimulus();
            checkOutput("tp4_zeroed", rdD, 32'h0);
        end

        fillAllSlots();
        lifeLoad = 1; lifeVal = 3;
        applyStimulus();
        lifeLoad = 0; lifeTick = 1;
        for (int t = 0; t < 3; t++) applyStimulus();
        checkOutput("tp5_expired", expired, 1'b1);
        checkOutput("tp5_not_busy_yet", busy, 1'b0);
        lifeTick = 0;
        applyStimulus();
        checkOutput("tp5_busy", busy, 1'b1);
        for (int t = 0; t < 8; t++) applyStimulus();
        checkOutput("tp5_cleared", slotValid, 8'h0);
        lifeLoad = 1; lifeVal = 5; lifeTick = 1;
        applyStimulus();
        lifeLoad = 0;
        for (int t = 0; t < 4; t++) applyStimulus();
        checkOutput("tp5_load_wins", expired, 1'b0);
        applyStimulus();
        checkOutput("tp5_expired5", expired, 1'b1);
        lifeTick = 0;
        for (int t = 0; t < 9; t++) applyStimulus();

        fillAllSlots();
        clrReq = 1;
        applyStimulus();
        clrReq = 0;
        for (int t = 0; t < 3; t++) applyStimulus();
        rst = 1;
        #1;
        checkOutput("tp6_busy", busy, 1'b0);
        checkOutput("tp6_valid", slotValid, 8'h0);
        checkOutput("tp6_key", keyData, '0);
        checkOutput("tp6_rd", rdD, 32'h0);
        checkOutput("tp6_ready", ldReady, 1'b0);
        checkOutput("tp6_err", ldErr, 1'b0);
        checkOutput("tp6_expired", expired, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        resetModel();
        #1;
        checkOutput("tp6_ready_after", ldReady, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            clrReq   = ($urandom_range(0, 99) < 1);
            lifeLoad = ($urandom_range(0, 99) < 2);
            lifeVal  = ($urandom_range(0, 9) == 0) ? 32'h0 : 32'($urandom_range(1, 40));
            lifeTick = ($urandom_range(0, 99) < 40);
            wrEn     = ($urandom_range(0, 99) < 30);
            wrSlot   = 3'($urandom());
            wrWord   = 4'($urandom());
            wrD      = $urandom();
            rdSlot   = 3'($urandom());
            rdWord   = 4'($urandom());
            keySlot  = 3'($urandom());
            ldValid  = ($urandom_range(0, 99) < 35);
            ldSlot   = 3'($urandom());
            ldNword  = 5'($urandom_range(0, 15));
            for (int i = 0; i < 12; i++) ldData[383-32*i -: 32] = $urandom();
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssk_bank.md
Name: ssk_bank

Overview:
- Parametrised session-key store; successor to the fixed-map session key memory.
- Holds NSLOT key slots of NWORD x DW bits each, loaded by CPU word writes or by a one-beat bulk load from the MAC/KDF engine (valid/ready).
- Adds per-slot valid flags, a session lifetime counter that auto-zeroizes on expiry, and a multi-cycle zeroize sweep with busy indication.
- Sits between the command decoder/KDF and the cipher/MAC datapaths, which read whole keys through key_data.

Parameters:
NSLOT  8    number of key slots
NWORD  12   words per slot
DW     32   word width
LDW    384  bulk-load bus width; LDW/DW is the maximum words per load
LIFE_W 32   lifetime counter width

Ports:
clk        in   1                   clock
rst        in   1                   asynchronous reset, active-high
clr_req    in   1                   start zeroize sweep
life_load  in   1                   load lifetime counter
life_val   in   LIFE_W              lifetime in ticks; 0 disables the counter
life_tick  in   1                   prescaled decrement strobe
expired    out  1                   one-cycle pulse when lifetime reaches 0
busy       out  1                   zeroize sweep in progress
wr_en      in   1                   CPU word write
wr_slot    in   clog2(NSLOT)        write slot
wr_word    in   clog2(NWORD)        write word index
wr_d       in   DW                  write data
rd_slot    in   clog2(NSLOT)        CPU read slot
rd_word    in   clog2(NWORD)        CPU read word
rd_d       out  DW                  read data, registered
ld_valid   in   1                   bulk load request
ld_ready   out  1                   bulk load accept
ld_slot    in   clog2(NSLOT)        target slot
ld_nword   in   clog2(LDW/DW)+1     words to load
ld_data    in   LDW                 load data; word 0 = ld_data[LDW-1 -: DW]
ld_err     out  1                   one-cycle pulse when a bad load is accepted
key_slot   in   clog2(NSLOT)        key read slot
key_data   out  NWORD*DW            full key, registered; word 0 at MSB
slot_valid out  NSLOT               per-slot valid flags

Behaviour:
- Reset: all words 0, slot_valid 0, FSM IDLE, lifetime counter 0/stopped. rd_d, key_data, expired, ld_err and busy are 0. ld_ready is 0 while rst is asserted.
- FSM IDLE:
  - clr_req or expiry -> ZERO next cycle, sweep index = 0.
- FSM ZERO:
  - Each cycle clears all words and the valid flag of the slot at the sweep index, then increments the index.
  - After slot NSLOT-1 is cleared -> IDLE. Sweep takes exactly NSLOT cycles; busy = 1 throughout.
  - clr_req during ZERO restarts the sweep at index 0.
  - wr_en and ld_valid are ignored. ld_ready = 0. rd_d and key_data read as 0.
- Write priority in IDLE: zeroize start > wr_en > bulk load.
- CPU write (wr_en, IDLE, in-range slot/word): one cycle.
  - wr_word == 0 writes word 0, zeroes words 1..NWORD-1 and sets slot_valid[wr_slot].
  - Any other word writes only that word.
  - Out-of-range slot or word: no effect.
- Bulk load:
  - ld_ready = IDLE and !wr_en and !clr_req and no expiry this cycle.
  - Transfer occurs on ld_valid and ld_ready in the same cycle.
  - For 1 <= ld_nword <= min(NWORD, LDW/DW): words 0..ld_nword-1 take the MSB-first DW chunks of ld_data, remaining words are zeroed, slot_valid is set.
  - ld_nword == 0, ld_nword out of range, or out-of-range ld_slot: accepted, no state change, ld_err pulses the next cycle.
- Reads:
  - rd_d is registered from (rd_slot, rd_word), 1-cycle latency, 0 if out of range.
  - key_data is registered, 1-cycle latency, 0 if the slot is invalid or out of range.
  - A read of a word being written in the same cycle returns the old value.
- Lifetime counter:
  - life_load loads life_val; it runs if life_val != 0. Load wins over a simultaneous tick.
  - Each life_tick while running decrements the counter. On the 1 -> 0 transition: the counter stops, expired pulses the same cycle as the register update, and the FSM enters ZERO next cycle.
  - The counter keeps running during ZERO.
  - life_load with life_val == 0 stops the counter without zeroizing.
- All arithmetic is unsigned. The sweep index and counter do not wrap.

Decomposition:
- Package ssk_pkg: FSM state enum (IDLE, ZERO), derived widths (SLOT_AW, WORD_AW, LD_NW), constant MAXLD = LDW/DW.
- Sub-module ssk_life_timer: lifetime counter with load/tick/expired, instantiated once.

Test Plan:
- Reset, then CPU write slot 2 word 0 = 0xA5A5A5A5 and word 5 = 0x12345678 -> slot_valid = 0x04; rd_d = 0x12345678 one cycle after (2,5); key_data MSB word = 0xA5A5A5A5, other non-written words 0.
- Bulk load slot 1, ld_nword = 8, ld_data MSB chunks 0x00000001..0x00000008 -> key_data words 0..7 = 1..8, words 8..11 = 0, slot_valid[1] = 1. Repeat with ld_nword = 0 -> ld_err pulse, slot unchanged.
- wr_en and ld_valid in the same cycle -> ld_ready = 0, write applied; load accepted the following cycle.
- Fill all slots, pulse clr_req -> busy high exactly 8 cycles, slot_valid clears one bit per cycle from bit 0; ld_ready = 0 and writes ignored during the sweep; all words 0 after.
- life_load = 3, three life_tick pulses -> expired pulses on the 3rd tick, busy rises the next cycle, all slots cleared. life_load = 5 coinciding with a tick -> counter = 5.
- Assert rst mid-sweep at index 3 -> all outputs 0 immediately; after release, FSM IDLE and ld_ready = 1.
